// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with optional iterative multiplier
//
// Purpose: accepts one operation per request (valid/ready), returns a registered
// result and flags (valid/ready). ADD/SUB/AND/OR/XOR/SLT/SHL complete in one cycle.
// MUL is an unsigned shift-add taking WIDTH cycles when ALU_SEQ_MUL_EN is defined;
// otherwise MUL is a one-cycle error op (result 0, err=1, z=1).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present          in_ready   request accepted (IDLE only)
//   op[2:0]    operation select         a, b       operands [WIDTH-1:0]
//   out_valid  result present (DONE)    out_ready  consumer takes result
//   result     [WIDTH-1:0]              flags[4:0] {err, v, n, z, c}
//
// Configuration macro: ALU_SEQ_MUL_EN

module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_flags;

  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_err;

`ifdef ALU_SEQ_MUL_EN
  // r_prod: upper half accumulates partial product, lower half holds the
  // not-yet-consumed multiplier bits; both shift right one bit per step.
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand;
  logic [SHW-1:0]     r_cnt;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic               w_mul_last;

  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                      (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};
  assign w_mul_last = (r_cnt == SHW'(WIDTH-1));
`endif

  // Single-cycle operations, evaluated directly on the request operands.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (op)
      3'b000: begin
        {w_c, w_res} = {1'b0, a} + {1'b0, b};
        w_v = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        // c=1 means no borrow
        {w_c, w_res} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        w_v = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: w_res = a & b;
      3'b011: w_res = a | b;
      3'b100: w_res = a ^ b;
      3'b101: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b110: w_res = a << b[SHW-1:0];
      default: begin
`ifndef ALU_SEQ_MUL_EN
        w_err = 1'b1;
`endif
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
          w_state_nxt = (op == 3'b111) ? S_BUSY : S_DONE;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
      S_BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        if (w_mul_last) w_state_nxt = S_DONE;
`else
        w_state_nxt = S_IDLE;
`endif
      end
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs depend on state only
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Datapath: result/flags change only on the edge that enters DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
`ifdef ALU_SEQ_MUL_EN
      r_prod   <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
`endif
    end else if (r_state == S_IDLE && in_valid) begin
`ifdef ALU_SEQ_MUL_EN
      if (op == 3'b111) begin
        r_prod  <= {{WIDTH{1'b0}}, b};
        r_mcand <= a;
        r_cnt   <= '0;
      end else begin
        r_result <= w_res;
        r_flags  <= {w_err, w_v, w_res[WIDTH-1], (w_res == '0), w_c};
      end
`else
      r_result <= w_res;
      r_flags  <= {w_err, w_v, w_res[WIDTH-1], (w_res == '0), w_c};
`endif
    end
`ifdef ALU_SEQ_MUL_EN
    else if (r_state == S_BUSY) begin
      r_prod <= w_prod_nxt;
      r_cnt  <= r_cnt + SHW'(1);
      if (w_mul_last) begin
        r_result <= w_prod_nxt[WIDTH-1:0];
        r_flags  <= {1'b0, 1'b0, w_prod_nxt[WIDTH-1],
                     (w_prod_nxt[WIDTH-1:0] == '0),
                     (|w_prod_nxt[2*WIDTH-1:WIDTH])};
      end
    end
`endif
  end

  assign result = r_result;
  assign flags  = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (WIDTH=16)

module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Present a request at a negedge and hold it through the accepting posedge.
  task automatic accept(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int guard;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; latency 1 means out_valid is already up.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic consume;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("exit_in_ready", {63'd0, in_ready}, 64'd1);
    chk("exit_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp_res,
                        input logic [4:0] exp_flg, input int exp_lat);
    int lat;
    accept(o, x, y);
    wait_valid(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(result), 64'(exp_res));
    chk({tag, "_flg"}, 64'(flags), 64'(exp_flg));
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    consume();
  endtask

  initial begin
    int seen;
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // flags = {err, v, n, z, c}
    run_op("add_wrap", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 5'b00011, 1);
    run_op("add_ovf",  3'b000, 16'h7FFF, 16'h0001, 16'h8000, 5'b01100, 1);
    run_op("sub_ovf",  3'b001, 16'h8000, 16'h0001, 16'h7FFF, 5'b01001, 1);
    run_op("sub_borrow", 3'b001, 16'h0001, 16'h0002, 16'hFFFF, 5'b00100, 1);
    run_op("slt_neg",  3'b101, 16'hFFFF, 16'h0001, 16'h0001, 5'b00000, 1);
    run_op("slt_pos",  3'b101, 16'h0001, 16'hFFFF, 16'h0000, 5'b00010, 1);
    run_op("and",      3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000, 1);
    run_op("xor_zero", 3'b100, 16'hAAAA, 16'hAAAA, 16'h0000, 5'b00010, 1);
    run_op("shl_mask", 3'b110, 16'h0001, 16'h0013, 16'h0008, 5'b00000, 1);

`ifdef ALU_SEQ_MUL_EN
    run_op("mul_ff",   3'b111, 16'h00FF, 16'h0101, 16'hFFFF, 5'b00100, 17);
    run_op("mul_hi",   3'b111, 16'h0100, 16'h0100, 16'h0000, 5'b00011, 17);
`else
    run_op("mul_off",  3'b111, 16'h0003, 16'h0004, 16'h0000, 5'b10010, 1);
`endif

    // Backpressure: DONE held for 5 cycles while a new request is offered
    accept(3'b011, 16'h8000, 16'h0001);
    wait_valid(lat);
    chk("bp_lat", 64'(lat), 64'd1);
    @(negedge clk);
    op = 3'b000; a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_result", 64'(result), 64'h8001);
      chk("bp_flags", 64'(flags), 64'h04);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_exit_in_ready", {63'd0, in_ready}, 64'd1);
    chk("bp_exit_out_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_idle_hold", 64'(result), 64'h8001);
    @(posedge clk);
    #1 chk("bp_no_accept", {63'd0, out_valid}, 64'd0);

    // Reset mid-operation (result currently 0x8001 from the previous op)
`ifdef ALU_SEQ_MUL_EN
    accept(3'b111, 16'h00FF, 16'h0101);
    repeat (7) @(posedge clk);
`else
    accept(3'b000, 16'h1234, 16'h0001);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    chk("mid_rst_flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("post_rst_no_stale", 64'(seen), 64'd0);
    chk("post_rst_result", 64'(result), 64'd0);

    run_op("or_after_rst", 3'b011, 16'h8000, 16'h0001, 16'h8001, 5'b00100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, 16, operand/result width in bits (legal 4..64, power of two).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock, the single clock of the block.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid in 1 request present; in_ready out 1 request accepted when both high.
REQ-005 SHALL have ports: op in 3 operation; a, b in WIDTH operands.
REQ-006 SHALL have ports: out_valid out 1 result present; out_ready in 1 consumer takes result when both high.
REQ-007 SHALL have ports: result out WIDTH; flags out 5 {err, v, n, z, c} (bit4..bit0).

Function
REQ-008 SHALL decode op as: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed a<b gives 1, else 0), 110 SHL (a shifted left logically by b[log2(WIDTH)-1:0]), 111 MUL.
REQ-009 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-010 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-011 SHALL, in IDLE with in_valid=1, capture op/a/b and go to DONE next cycle for ops 000-110, or to BUSY for MUL.
REQ-012 SHALL give a latency of 1 cycle (accept edge to out_valid) for ops 000-110.
REQ-013 SHALL compute SUB as a + ~b + 1, with c = carry-out (1 = no borrow).
REQ-014 SHALL compute ADD c = carry-out; v = signed overflow for ADD/SUB; c=v=0 for all other ops.
REQ-015 SHALL compute MUL iteratively as unsigned shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY, giving out_valid WIDTH+1 cycles after the accept edge.
REQ-016 SHALL set result to the low WIDTH bits of the product for MUL, with c=1 iff any high WIDTH product bit is nonzero.
REQ-017 SHALL set z=(result==0) and n=result[WIDTH-1] for every op; err=0 except as in REQ-025.
REQ-018 SHALL hold result and flags stable in DONE until out_valid&&out_ready, then go to IDLE the next cycle.
REQ-019 SHALL give no new accept in the DONE exit cycle; back-to-back throughput is one op per 2 cycles minimum.
REQ-020 SHALL ignore in_valid while in BUSY or DONE (in_ready=0), with no state change.
REQ-021 SHALL have result/flags hold their last value in IDLE and BUSY, and not be qualified except by out_valid.

Reset
REQ-022 SHALL, on rst_n low, immediately (asynchronously) force state IDLE, out_valid=0, result=0, flags=0, and clear internal multiplier registers.
REQ-023 SHALL abort a reset asserted during BUSY or DONE without output; in_ready=1 on the first edge after rst_n rises.

Configuration
REQ-024 SHALL, with macro ALU_SEQ_MUL_EN defined, implement MUL per REQ-015/016.
REQ-025 SHALL, without ALU_SEQ_MUL_EN, contain no multiplier logic, and treat op 111 as a 1-cycle op with result=0, flags={err=1, v=0, n=0, z=1, c=0}.

Verification (WIDTH=16, ALU_SEQ_MUL_EN defined unless noted)
REQ-026 SHALL check ADD a=0xFFFF b=0x0001 -> result 0x0000, c=1, z=1, v=0, out_valid 1 cycle after accept.
REQ-027 SHALL check SUB a=0x8000 b=0x0001 -> 0x7FFF, c=1, v=1, n=0; SLT a=0xFFFF b=0x0001 -> 0x0001.
REQ-028 SHALL check MUL 0x00FF*0x0101 -> 0xFFFF, c=0, out_valid exactly 17 cycles after accept; then MUL 0x0100*0x0100 -> 0x0000, c=1, z=1.
REQ-029 SHALL check backpressure: hold out_ready=0 for 5 cycles in DONE -> result/flags unchanged, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-030 SHALL check that rst_n pulsed low 8 cycles into a MUL -> out_valid=0, result=0 immediately; in_ready=1 after release; no stale result appears.
REQ-031 SHALL check, with ALU_SEQ_MUL_EN undefined, MUL 0x0003*0x0004 -> result 0x0000, err=1, z=1, 1-cycle latency.
